mnist_pixel_loader: RTL
=======================

// Module: mnist_pixel_loader
// PURPOSE
//   Streams one 28x28 uint8 image into the int8 input buffer that FC1 reads (x_mem).
//   Sits directly upstream of FC1: accepts bytes from a UART or DMA byte source
//   over a valid/ready handshake, quantises each byte to int8 and issues memory writes.
//   Signals frame_ready once the whole image is committed. Holds off further input
//   until the top FSM releases the buffer.
// PARAMETERS
//   N_PIX      784  pixels per frame; write address range 0..N_PIX-1
//   PIX_SHIFT  1    right shift of uint8 pixel before int8 store (legal range 1..7)
//   ADDR_W     $clog2(N_PIX)  width of x_addr (derived, do not override)
// PORTS
//   clk          in   1       single clock; all logic on posedge
//   rst          in   1       asynchronous, active-high reset
//   s_valid      in   1       input byte valid
//   s_ready      out  1       loader can accept a byte this cycle
//   s_data       in   8       unsigned pixel value
//   s_last       in   1       source end-of-frame marker (optional framing)
//   x_we         out  1       write strobe into the x buffer
//   x_addr       out  ADDR_W  write address
//   x_data       out  8       signed int8 pixel value
//   frame_ready  out  1       level: full frame committed, buffer owned by consumer
//   release      in   1       pulse from top: consumer finished reading (after fc1_done)
//   err_short    out  1       1-cycle pulse: s_last arrived before pixel N_PIX-1
//   frame_cnt    out  8       completed-frame counter, wraps 255->0
// BEHAVIOUR
//   Reset values: s_ready=0, x_we=0, x_addr=0, x_data=0, frame_ready=0, err_short=0,
//     frame_cnt=0, pixel counter=0, state=LOAD.
//   Beat: accepted only when s_valid & s_ready; nothing else advances the counter.
//   Quantise: x_data = {PIX_SHIFT'b0, s_data[7:PIX_SHIFT]}, always >= 0.
//     With PIX_SHIFT=1 the mapping is 255->127 and 0->0.
//   Latency: write is registered. x_we/x_addr/x_data are valid the cycle after the beat.
//     x_addr equals the beat index within the frame.
//   FSM:
//     LOAD  - s_ready=1. Each beat writes the counter address, then the counter increments.
//             On the beat at counter N_PIX-1: counter->0, go to FLUSH.
//             s_last is ignored on that beat.
//             s_last on any earlier beat: this beat is still written.
//             err_short pulses the next cycle, the counter resets to 0, state stays LOAD.
//             A partial frame is never flagged ready.
//     FLUSH - s_ready=0. Lasts one cycle while the final write commits.
//             Then go to FULL, set frame_ready=1, and increment frame_cnt.
//     FULL  - s_ready=0 and frame_ready=1. s_valid is ignored; no writes occur.
//             On release: frame_ready=0 and go to LOAD. s_ready=1 the next cycle.
//   Timing: frame_ready rises 2 cycles after the final beat (1 for the write, 1 for FLUSH).
//     The consumer therefore never reads a stale final pixel.
//   release is ignored in LOAD and FLUSH; it does not abort a frame in progress.
//   Back-to-back beats are allowed at 1 beat/cycle with no bubbles inside a frame.
//   Reset mid-frame: outputs return to reset values immediately (async).
//     The counter restarts at 0 and buffer contents are undefined.
//     frame_ready stays 0 until a complete new frame is loaded.
//   s_ready depends only on state, never on s_valid (no combinational path).
// STRUCTURE
//   Shared package mnist_pkg:
//     - localparams N_PIX=784, PIX_W=8, N_H1=32, N_OUT=10
//     - state encoding LD_LOAD/LD_FLUSH/LD_FULL
//     - function pix_quant(uint8, shift) -> int8, reused by the bench model
//   No sub-module: single FSM plus pixel counter, write register and frame counter.
//   In top, mnist_pixel_loader replaces the static initial load of the input image.
//   x_we/x_addr/x_data drive the x_mem write port.
//   frame_ready gates T_WAIT (and replaces start_btn_edge).
//   release is driven on fc1_done.
// TESTING
//   1. Send 784 beats, s_data=i[7:0], no stalls.
//      -> x_mem[i] == (i%256)>>1. frame_ready rises 2 cycles after the last beat.
//      -> frame_cnt == 1.
//   2. Toggle s_valid randomly (~50%) over a frame.
//      -> Exactly 784 writes, addresses strictly 0..783 in order, no write while s_valid=0.
//   3. Assert s_last on beat 99, then send a full 784-beat frame.
//      -> err_short pulses once. Writes restart at addr 0. frame_ready only after the full frame.
//   4. In FULL, hold s_valid=1 for 50 cycles, then pulse release.
//      -> s_ready=0 and no x_we throughout; s_ready=1 the cycle after release.
//      -> frame_ready=0.
//   5. Assert rst at beat 400, then send a full frame.
//      -> All outputs return to reset values during rst. The new frame writes from addr 0.
//      -> frame_cnt == 1 after it.
//   6. Load 256 frames, each followed by release.
//      -> frame_cnt wraps to 0. Pixel 255 stored as 127 in every frame.

Source files
------------

// File: rtl/mnist_pkg.sv
// Shared constants, loader state encoding and pixel quantiser for the MNIST datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mnist_pkg;

   localparam int N_PIX = 784;
   localparam int PIX_W = 8;
   localparam int N_H1  = 32;
   localparam int N_OUT = 10;

   typedef enum logic [1:0] {
      LD_LOAD  = 2'd0,
      LD_FLUSH = 2'd1,
      LD_FULL  = 2'd2
   } ld_state_t;

   // uint8 -> non-negative int8 by a logical right shift; the top bit is always cleared.
   function automatic logic signed [PIX_W-1:0] pix_quant(input logic [PIX_W-1:0] pix,
                                                         input int shift);
      pix_quant = $signed(pix >> shift);
   endfunction

endpackage

// File: rtl/mnist_pixel_loader.sv
// Purpose: stream one 28x28 uint8 frame into the int8 x buffer and hand it to FC1.
// Latency: write strobe 1 cycle after a beat; frame_ready 2 cycles after the final beat.
// Backpressure: s_ready is registered from state only; low while the frame is flushed/owned.
// The consumer-release input is named buf_release because "release" is a reserved word.
module mnist_pixel_loader #(
   parameter  int N_PIX     = mnist_pkg::N_PIX,
   parameter  int PIX_SHIFT = 1,
   localparam int ADDR_W    = $clog2(N_PIX)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [7:0]               s_data,
   input  logic                     s_last,
   output logic                     x_we,
   output logic [ADDR_W-1:0]        x_addr,
   output logic signed [7:0]        x_data,
   output logic                     frame_ready,
   input  logic                     buf_release,
   output logic                     err_short,
   output logic [7:0]               frame_cnt
);
   import mnist_pkg::*;

   ld_state_t         state;
   ld_state_t         state_nxt;
   logic [ADDR_W-1:0] pix_cnt;
   logic              beat;
   logic              last_pix;
   logic              short_end;

   assign beat      = s_valid & s_ready;
   assign last_pix  = (pix_cnt == ADDR_W'(N_PIX - 1));
   // s_last on the final pixel is just the normal end of frame, not an error.
   assign short_end = beat & s_last & ~last_pix;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= LD_LOAD;
      else     state <= state_nxt;
   end

   // Next-state: fill, one flush cycle for the last write, then hold until released.
   always_comb begin
      state_nxt = state;
      case (state)
         LD_LOAD:  if (beat && last_pix) state_nxt = LD_FLUSH;
         LD_FLUSH: state_nxt = LD_FULL;
         LD_FULL:  if (buf_release) state_nxt = LD_LOAD;
         default:  state_nxt = LD_LOAD;
      endcase
   end

   // s_ready tracks the upcoming state so it is 0 in reset and has no path from s_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) s_ready <= 1'b0;
      else     s_ready <= (state_nxt == LD_LOAD);
   end

   // Pixel counter: advances per beat, wraps at frame end or on an early s_last.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_cnt <= '0;
      end else if (beat) begin
         if (last_pix || s_last) pix_cnt <= '0;
         else                    pix_cnt <= pix_cnt + 1'b1;
      end
   end

   // Registered write port into x_mem plus the short-frame error pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_we      <= 1'b0;
         x_addr    <= '0;
         x_data    <= '0;
         err_short <= 1'b0;
      end else begin
         x_we      <= beat;
         err_short <= short_end;
         if (beat) begin
            x_addr <= pix_cnt;
            x_data <= pix_quant(s_data, PIX_SHIFT);
         end
      end
   end

   // Frame handoff: ready after the flush cycle, cleared when the consumer releases.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_ready <= 1'b0;
         frame_cnt   <= '0;
      end else if (state == LD_FLUSH) begin
         frame_ready <= 1'b1;
         frame_cnt   <= frame_cnt + 8'd1;
      end else if (state == LD_FULL && buf_release) begin
         frame_ready <= 1'b0;
      end
   end

endmodule
